matrix_det_unit: RTL and testbench
==================================

MATRIX_DET_UNIT -- requirements
Module: matrix_det_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning matrix element width in bits, signed two's complement.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning memory address width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request pulse, sampled in IDLE only.
REQ-006 The block SHALL have port mode  input  1  matrix size select: 0 = 2x2, 1 = 3x3; sampled with start.
REQ-007 The block SHALL have port start_address  input  ADDR_W  address of element [0][0]; sampled with start.
REQ-008 The block SHALL have port data_in  input  DATA_W  memory read data, valid one cycle after the address is presented.
REQ-009 The block SHALL have port address_to_memory  output  ADDR_W  read address.
REQ-010 The block SHALL have port mem_rd  output  1  high while address_to_memory carries a valid read address.
REQ-011 The block SHALL have port out  output  3*DATA_W+1  signed determinant result.
REQ-012 The block SHALL have port busy  output  1  high in every state other than IDLE.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse; out is valid from this cycle onward.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, COMPUTE and DONE, with transitions IDLE->FETCH on start, FETCH->COMPUTE, COMPUTE->DONE and DONE->IDLE.
REQ-015 Elements SHALL be stored row-major, with element k at start_address+k, k = 0..N-1, where N = 4 for 2x2 and 9 for 3x3.
REQ-016 Address arithmetic SHALL wrap modulo 2^ADDR_W (for example, start 14 with 2x2 reads 14, 15, 0, 1).
REQ-017 FETCH SHALL last N+1 cycles: addresses are issued on cycles 1..N with mem_rd=1, data is captured one cycle later into the internal element registers, and mem_rd is 0 on the final cycle.
REQ-018 COMPUTE SHALL take 1 cycle for 2x2 (a*d - b*c) and 3 cycles for 3x3.
REQ-019 For 3x3, COMPUTE SHALL use cofactor expansion along row 0, accumulating one signed term per cycle: +m00*(m11*m22-m12*m21), -m01*(m10*m22-m12*m20), +m02*(m10*m21-m11*m20).
REQ-020 All arithmetic SHALL be signed and performed at the full 3*DATA_W+1 width, so that no overflow is possible; a 2x2 result SHALL be sign-extended.
REQ-021 done SHALL be high exactly N+K+1 rising edges after the edge that samples start, where K is the COMPUTE length (2x2: 6 edges; 3x3: 13 edges).
REQ-022 out SHALL hold its value from done until the next DONE state; it SHALL NOT change during a subsequent FETCH or COMPUTE.
REQ-023 start SHALL be ignored while busy=1; mode and start_address changes while busy=1 SHALL have no effect.
REQ-024 A start that is high in the cycle after done (IDLE) SHALL begin a new operation immediately.
REQ-025 When not in FETCH, address_to_memory SHALL be driven to 0.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately force IDLE and drive out=0, done=0, busy=0, mem_rd=0, address_to_memory=0, and clear the element registers and accumulator.
REQ-027 A reset asserted mid-operation SHALL abort that operation; no done pulse SHALL follow.
REQ-028 After reset_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-029 The block SHALL use the macro DET_3X3_EN to compile the 3x3 mode in or out.
REQ-030 With DET_3X3_EN defined, the block SHALL support both modes exactly as specified above.
REQ-031 Without DET_3X3_EN, mode SHALL be ignored, every operation SHALL run as 2x2, and the 3x3 datapath, the nine-element storage and the 3-cycle COMPUTE SHALL be absent; out width SHALL be unchanged.

Verification
REQ-032 DATA_W=8, mode=0, start_address=0, memory [3,2,1,4] -> addresses 0,1,2,3; done 6 edges after start; out=10.
REQ-033 mode=0, memory [-128,127,127,-128] -> out=255; memory [-128,-128,127,-128] -> out=32640, with no overflow.
REQ-034 mode=1, start_address=2, memory [2,0,1,1,3,2,1,1,2] -> addresses 2..10; done 13 edges after start; out=6.
REQ-035 mode=0, start_address=14 -> addresses 14,15,0,1 in that order, and the result is correct.
REQ-036 A second start during FETCH is ignored; reset_n pulsed low mid-COMPUTE -> out=0, busy=0, no done; the next start completes normally.
REQ-037 Build without DET_3X3_EN, mode=1, memory [3,2,1,4] -> four reads only; out=10.

Source files
------------

// File: rtl/matrix_det_unit.sv
// matrix_det_unit: determinant of a 2x2 or 3x3 signed matrix read row-major
// from a synchronous memory (read data valid one cycle after the address).
// Build option: define DET_3X3_EN to compile in 3x3 support; without it every
// operation runs as 2x2 and the mode input is ignored.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | N+1 cycles: issue N reads, capture data one cycle behind
// COMPUTE | 1 cycle (2x2) or 3 cycles (3x3, one cofactor term per cycle)
// DONE    | one cycle, done pulse, result published on out
module matrix_det_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       mode,
  input  logic [ADDR_W-1:0]          start_address,
  input  logic signed [DATA_W-1:0]   data_in,
  output logic [ADDR_W-1:0]          address_to_memory,
  output logic                       mem_rd,
  output logic signed [3*DATA_W:0]   out,
  output logic                       busy,
  output logic                       done
);

  localparam int OW = 3*DATA_W + 1;
`ifdef DET_3X3_EN
  localparam int NMAX = 9;
`else
  localparam int NMAX = 4;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, DONE} state_t;

  state_t                    state_q;
  logic [ADDR_W-1:0]         addr_q;
  logic                      mem_rd_q;
  logic                      busy_q;
  logic                      done_q;
  logic [3:0]                idx_q;
  logic [3:0]                n_cur;
  logic signed [OW-1:0]      out_q;
  logic signed [OW-1:0]      acc_q;
  logic signed [OW-1:0]      acc_d;
  logic signed [OW-1:0]      term_d;
  // Shift register: the first element fetched ends up at index n-1, the last at 0.
  logic signed [DATA_W-1:0]  elem_q [NMAX];
  logic signed [OW-1:0]      e [NMAX];

`ifdef DET_3X3_EN
  logic                      mode_q;
  logic [1:0]                step_q;
  logic [3:0]                n_q;
  assign n_cur = n_q;
`else
  logic                      unused_mode;
  assign unused_mode = mode;
  assign n_cur = 4'd4;
`endif

  function automatic logic signed [OW-1:0] sx(input logic signed [DATA_W-1:0] v);
    return {{(OW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Sign-extend every stored element to the full result width.
  always_comb begin
    for (int i = 0; i < NMAX; i++) begin
      e[i] = sx(elem_q[i]);
    end
  end

  // Term added to the accumulator in the current COMPUTE cycle.
  // 3x3 mapping: m[r][c] lives at e[8-(3r+c)]; 2x2: a=e3, b=e2, c=e1, d=e0.
  always_comb begin
    term_d = '0;
`ifdef DET_3X3_EN
    if (mode_q) begin
      case (step_q)
        2'd2:    term_d =   e[8] * (e[4]*e[0] - e[3]*e[1]);
        2'd1:    term_d = -(e[7] * (e[5]*e[0] - e[3]*e[2]));
        default: term_d =   e[6] * (e[5]*e[1] - e[4]*e[2]);
      endcase
    end else begin
      term_d = e[3]*e[0] - e[2]*e[1];
    end
`else
    term_d = e[3]*e[0] - e[2]*e[1];
`endif
    acc_d = acc_q + term_d;
  end

  // Control FSM with registered memory interface and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      out_q    <= '0;
      acc_q    <= '0;
      for (int i = 0; i < NMAX; i++) begin
        elem_q[i] <= '0;
      end
`ifdef DET_3X3_EN
      mode_q   <= 1'b0;
      step_q   <= '0;
      n_q      <= 4'd4;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= FETCH;
            busy_q   <= 1'b1;
            addr_q   <= start_address;
            mem_rd_q <= 1'b1;
            idx_q    <= '0;
            acc_q    <= '0;
`ifdef DET_3X3_EN
            mode_q   <= mode;
            n_q      <= mode ? 4'd9 : 4'd4;
`endif
          end
        end
        FETCH: begin
          // Data for the read issued in cycle idx-1 is on data_in now.
          if (idx_q != 4'd0) begin
            elem_q[0] <= data_in;
            for (int i = NMAX-1; i > 0; i--) begin
              elem_q[i] <= elem_q[i-1];
            end
          end
          if (idx_q == n_cur) begin
            state_q <= COMPUTE;
`ifdef DET_3X3_EN
            step_q  <= mode_q ? 2'd2 : 2'd0;
`endif
          end else begin
            idx_q <= idx_q + 4'd1;
            if ((idx_q + 4'd1) < n_cur) begin
              addr_q <= addr_q + ADDR_W'(1);
            end else begin
              addr_q   <= '0;
              mem_rd_q <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          acc_q <= acc_d;
`ifdef DET_3X3_EN
          if (step_q == 2'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            out_q   <= acc_d;
          end else begin
            step_q <= step_q - 2'd1;
          end
`else
          state_q <= DONE;
          done_q  <= 1'b1;
          out_q   <= acc_d;
`endif
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address_to_memory = addr_q;
  assign mem_rd            = mem_rd_q;
  assign out               = out_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_matrix_det_unit.sv
// Bench for matrix_det_unit: table of directed vectors, abort/restart sequence,
// then random matrices checked against a plain-arithmetic determinant model.
module tb_matrix_det_unit;

`ifdef DET_3X3_EN
  localparam bit EN3 = 1'b1;
`else
  localparam bit EN3 = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic               mode;
  logic [3:0]         start_address;
  logic signed [7:0]  data_in;
  logic [3:0]         address_to_memory;
  logic               mem_rd;
  logic signed [24:0] out;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;
  int last_out = 0;

  logic [7:0] mem [16];
  int rd_log[$];

  matrix_det_unit #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .mode              (mode),
    .start_address     (start_address),
    .data_in           (data_in),
    .address_to_memory (address_to_memory),
    .mem_rd            (mem_rd),
    .out               (out),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for an address appears one cycle later.
  always @(posedge clk) data_in <= mem[address_to_memory];

  // Record every address presented with mem_rd high.
  always @(posedge clk) if (mem_rd) rd_log.push_back(int'(address_to_memory));

  typedef struct {
    bit m;
    int sa;
    int v[9];
    int exp;
    bit dup;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int n_of(input bit m);
    return (m && EN3) ? 9 : 4;
  endfunction

  // Reference: Sarrus rule for 3x3, ad-bc for 2x2.
  function automatic int ref_det(input bit m, input int v[9]);
    if (n_of(m) == 9)
      return v[0]*v[4]*v[8] + v[1]*v[5]*v[6] + v[2]*v[3]*v[7]
           - v[2]*v[4]*v[6] - v[1]*v[3]*v[8] - v[0]*v[5]*v[7];
    return v[0]*v[3] - v[1]*v[2];
  endfunction

  task automatic load_mem(input int sa, input int v[9], input int n);
    for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
    for (int k = 0; k < n; k++) mem[(sa + k) % 16] = 8'(v[k]);
  endtask

  task automatic run_op(input string tag, input bit m, input int sa, input int v[9],
                        input int exp, input bit rel, input bit dup);
    int n, kc, edges, guard, bad;
    bit seen;
    n  = n_of(m);
    kc = (n == 9) ? 3 : 1;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    load_mem(sa, v, n);
    rd_log.delete();
    if (rel) reset_n = 1'b1;
    start = 1'b1;
    mode = m;
    start_address = 4'(sa);
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 1'($urandom);
    start_address = 4'($urandom);
    chk({tag, "/busy"}, int'(busy), 1);
    edges = 0;
    seen = 1'b0;
    while (edges < 40 && !seen) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 2) begin
        chk({tag, "/out_hold"}, int'(out), last_out);
        if (dup) begin
          start = 1'b1;
          mode = ~m;
          start_address = 4'(sa + 5);
        end
      end else if (edges == 3) begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    chk({tag, "/done_edges"}, edges, n + kc + 1);
    chk({tag, "/out"}, int'(out), exp);
    chk({tag, "/reads"}, rd_log.size(), n);
    bad = 0;
    for (int j = 0; j < n; j++)
      if (j >= rd_log.size() || rd_log[j] != (sa + j) % 16) bad++;
    chk({tag, "/addr_seq"}, bad, 0);
    @(posedge clk);
    #1;
    chk({tag, "/done_pulse"}, int'(done), 0);
    chk({tag, "/idle"}, int'(busy), 0);
    last_out = exp;
  endtask

  initial begin
    int v[9];
    int dcnt;
    bit rm;
    int rsa;

    reset_n = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    start_address = '0;
    for (int a = 0; a < 16; a++) mem[a] = '0;

    tbl[0].m = 0; tbl[0].sa = 0;  tbl[0].v = '{3, 2, 1, 4, 0, 0, 0, 0, 0};        tbl[0].exp = 10;    tbl[0].dup = 0;
    tbl[1].m = 0; tbl[1].sa = 5;  tbl[1].v = '{-128, 127, 127, -128, 0, 0, 0, 0, 0}; tbl[1].exp = 255; tbl[1].dup = 0;
    tbl[2].m = 0; tbl[2].sa = 9;  tbl[2].v = '{-128, -128, 127, -128, 0, 0, 0, 0, 0}; tbl[2].exp = 32640; tbl[2].dup = 1;
    tbl[3].m = 0; tbl[3].sa = 14; tbl[3].v = '{3, 2, 1, 4, 0, 0, 0, 0, 0};        tbl[3].exp = 10;    tbl[3].dup = 0;
`ifdef DET_3X3_EN
    tbl[4].m = 1; tbl[4].sa = 2;  tbl[4].v = '{2, 0, 1, 1, 3, 2, 1, 1, 2};        tbl[4].exp = 6;     tbl[4].dup = 1;
`else
    tbl[4].m = 1; tbl[4].sa = 2;  tbl[4].v = '{3, 2, 1, 4, 0, 0, 0, 0, 0};        tbl[4].exp = 10;    tbl[4].dup = 0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst/out", int'(out), 0);
    chk("rst/busy", int'(busy), 0);
    chk("rst/done", int'(done), 0);
    chk("rst/mem_rd", int'(mem_rd), 0);
    chk("rst/addr", int'(address_to_memory), 0);

    // First op releases reset on the same edge that samples start.
    for (int i = 0; i < 5; i++)
      run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].sa, tbl[i].v, tbl[i].exp, (i == 0), tbl[i].dup);

    // Abort in COMPUTE: reset clears everything and no done follows.
    v = '{5, -3, 7, 2, 0, 0, 0, 0, 0};
    @(negedge clk);
    load_mem(3, v, 4);
    start = 1'b1;
    mode = 1'b0;
    start_address = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort/busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("abort/out", int'(out), 0);
    chk("abort/busy", int'(busy), 0);
    chk("abort/done", int'(done), 0);
    chk("abort/mem_rd", int'(mem_rd), 0);
    @(negedge clk);
    reset_n = 1'b1;
    last_out = 0;
    dcnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("abort/no_done", dcnt, 0);
    run_op("after_abort", 1'b0, 3, v, ref_det(1'b0, v), 1'b0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      rm = 1'($urandom);
      rsa = int'($urandom_range(0, 15));
      for (int j = 0; j < 9; j++) v[j] = int'($urandom_range(0, 255)) - 128;
      run_op($sformatf("rand%0d", it), rm, rsa, v, ref_det(rm, v), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
